threshold_writeback: RTL
========================

// Module: threshold_writeback
// PURPOSE
//  Downstream of the 4-lane DMA read stage. Buffers each lane in a small FIFO and
//  restores raster order by draining lanes 0,1,2,3,0,... Binarizes each pixel
//  against a threshold and writes the result to the output memory at OUT_BASE+index.
//  Asserts done once IMAGE_SIZE result pixels have been written.
// PARAMETERS
//  IMAGE_SIZE  4096   pixels per frame; must be a multiple of 4
//  THRESHOLD   128    default threshold; pixel >= THRESHOLD -> 8'hFF, else 8'h00
//  LANE_DEPTH  4      entries per lane FIFO; power of 2, >= 2
//  OUT_BASE    32'h0  byte address of result pixel 0
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-low
//  start          in   1   level; run while high, return to IDLE when low
//  done           out  1   frame written; held until start goes low
//  lane_data_0..3 in   8   pixel for lane N (raster pixel k uses lane k%4)
//  lane_valid_0..3 in  1   one-cycle strobe; one pixel per high cycle
//  lane_full_0..3 out  1   lane N FIFO full (combinational from count)
//  wr_addr        out  32  result write address
//  wr_data        out  8   binarized pixel
//  wr_en          out  1   one-cycle write strobe
//  mem_rw         out  1   constant 1 (write)
//  overflow       out  1   sticky: a strobe hit a full lane; cleared on IDLE->RUN
//  pix_count      out  32  result pixels written this frame
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; done, wr_en, overflow = 0; wr_addr = OUT_BASE;
//   wr_data = 0; pix_count = 0; FIFOs empty; lane pointer = 0.
//  FSM:
//   - IDLE -> RUN when start=1. On entry: clear FIFOs, pix_count, lane pointer, overflow.
//   - RUN -> DONE when the write of pixel IMAGE_SIZE-1 is issued. done=1 from the next cycle.
//   - RUN or DONE -> IDLE when start=0; FIFO contents are discarded.
//  Push rules:
//   - Strobes are accepted only in RUN.
//   - A strobe to a full lane drops the pixel and sets overflow. The FIFO is not modified.
//   - Exception: if the same lane is popped in that cycle, the push is accepted
//     (no overflow, since the pop frees the slot).
//  Pop rules:
//   - In RUN, each cycle: if the FIFO at the lane pointer is non-empty, pop it.
//   - On a pop: register wr_en=1, wr_data=(pix>=thr)?8'hFF:8'h00,
//     wr_addr=OUT_BASE+pix_count. Then pix_count+1, lane pointer+1 (wraps 3->0).
//   - If that FIFO is empty: wr_en=0 and the pointer stalls. Other lanes are never
//     popped out of order.
//  Throughput and latency:
//   - Throughput: at most 1 pixel per cycle.
//   - Latency: a strobe sampled at edge t may appear on wr_en after edge t+1
//     (FIFO write at t, output register at t+1), provided its lane is next in order.
//   - Push and pop of an empty lane in the same cycle: no bypass. Pop occurs next cycle.
//  Arithmetic:
//   - wr_addr is a 32-bit unsigned add; wraps modulo 2^32.
//   - Compare is unsigned 8-bit. thr=0 -> all 8'hFF; thr=255 -> only 255 maps to 8'hFF.
//  Reset mid-frame: immediate return to reset values, regardless of state.
//  DONE: no pops, strobes ignored, wr_en=0; outputs other than wr_en hold.
// CONFIGURATION
//  THRESH_RUNTIME_EN defined:
//   - Adds input threshold_in [7:0].
//   - Sampled into a register on the IDLE->RUN transition; used for the whole frame.
//   - Changes mid-frame have no effect.
//  THRESH_RUNTIME_EN undefined:
//   - No threshold_in port; THRESHOLD is used as a constant.
// TESTING
//  1 IMAGE_SIZE=16, pixels k*16 fed in order at one strobe per cycle, THRESHOLD=128
//    -> 16 writes at addr 0..15; data 00 for k<8, FF for k>=8; done=1; pix_count=16.
//  2 Lane 1 strobes delayed 5 cycles vs lanes 0,2,3 -> wr_en stalls after addr 0.
//    Writes stay in raster order 0,1,2,...; no overflow with LANE_DEPTH=4.
//  3 Five strobes on lane 2 while lane 0 starves -> 5th pixel dropped, overflow=1.
//    overflow stays 1 until start is toggled low then high, then reads 0.
//  4 Pixel values 127, 128, 0, 255 with THRESHOLD=128 -> data 00, FF, 00, FF.
//    With THRESH_RUNTIME_EN and threshold_in=0 sampled at start -> FF, FF, FF, FF.
//  5 reset=0 asserted after pix_count=7 -> all outputs at reset values immediately.
//    After release with start=1 -> frame restarts at addr OUT_BASE.
//  6 done=1, then start=0 for 1 cycle, then start=1 -> done=0, pix_count=0.
//    The second frame writes addr 0..IMAGE_SIZE-1 again.

Source files
------------

// File: rtl/threshold_writeback.sv
// Four-lane reorder FIFOs, binarizing threshold and raster-order result writer.
// Optional runtime threshold input enabled by THRESH_RUNTIME_EN.
module threshold_writeback #(
  parameter int          IMAGE_SIZE = 4096,
  parameter int          THRESHOLD  = 128,
  parameter int          LANE_DEPTH = 4,
  parameter logic [31:0] OUT_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef THRESH_RUNTIME_EN
  input  logic [7:0]  threshold_in,
`endif
  output logic        done,
  input  logic [7:0]  lane_data_0,
  input  logic [7:0]  lane_data_1,
  input  logic [7:0]  lane_data_2,
  input  logic [7:0]  lane_data_3,
  input  logic        lane_valid_0,
  input  logic        lane_valid_1,
  input  logic        lane_valid_2,
  input  logic        lane_valid_3,
  output logic        lane_full_0,
  output logic        lane_full_1,
  output logic        lane_full_2,
  output logic        lane_full_3,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        mem_rw,
  output logic        overflow,
  output logic [31:0] pix_count
);

  localparam int AW = $clog2(LANE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] THR8 = 8'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]    r_mem [4][LANE_DEPTH];
  logic [AW-1:0] r_wp [4];
  logic [AW-1:0] r_rp [4];
  logic [CW-1:0] r_cnt [4];
  logic [1:0]    r_lane;
  logic [31:0]   r_pix;
  logic [31:0]   r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_wr_en;
  logic          r_ovf;

  logic [7:0] w_ldata [4];
  logic [3:0] w_lvalid;
  logic [3:0] w_push;
  logic [3:0] w_pop;
  logic [3:0] w_full;
  logic [3:0] w_drop;
  logic       w_pop_any;
  logic       w_last;
  logic       w_start_run;
  logic       w_clear;
  logic [7:0] w_pix;
  logic [7:0] w_thr;

  assign w_ldata[0] = lane_data_0;
  assign w_ldata[1] = lane_data_1;
  assign w_ldata[2] = lane_data_2;
  assign w_ldata[3] = lane_data_3;
  assign w_lvalid   = {lane_valid_3, lane_valid_2,
                       lane_valid_1, lane_valid_0};

`ifdef THRESH_RUNTIME_EN
  logic [7:0] r_thr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_thr <= THR8;
    end else if (w_start_run) begin
      r_thr <= threshold_in;
    end
  end

  assign w_thr = r_thr;
`else
  assign w_thr = THR8;
`endif

  always_comb begin
    w_pop     = '0;
    w_pop_any = 1'b0;
    w_pix     = r_mem[r_lane][r_rp[r_lane]];
    if (r_state == S_RUN && r_cnt[r_lane] != '0) begin
      w_pop[r_lane] = 1'b1;
      w_pop_any     = 1'b1;
    end
    // A pop in the same cycle frees the slot for a push to a full lane
    for (int i = 0; i < 4; i++) begin
      w_full[i] = (r_cnt[i] == CW'(LANE_DEPTH));
      w_push[i] = (r_state == S_RUN) && w_lvalid[i]
                  && (!w_full[i] || w_pop[i]);
      w_drop[i] = (r_state == S_RUN) && w_lvalid[i]
                  && w_full[i] && !w_pop[i];
    end
  end

  assign w_last = w_pop_any && (r_pix == 32'(IMAGE_SIZE - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN: begin
        if (!start)      w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  if (!start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_start_run = (r_state == S_IDLE) && start;
  assign w_clear     = w_start_run
                       || (r_state != S_IDLE && w_next == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_lane    <= 2'd0;
      r_pix     <= 32'd0;
      r_wr_addr <= OUT_BASE;
      r_wr_data <= 8'h00;
      r_wr_en   <= 1'b0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_wr_en <= w_pop_any;
      if (w_pop_any) begin
        r_wr_data <= (w_pix >= w_thr) ? 8'hFF : 8'h00;
        r_wr_addr <= OUT_BASE + r_pix;
        r_pix     <= r_pix + 32'd1;
        r_lane    <= r_lane + 2'd1;
      end
      if (w_drop != '0) r_ovf <= 1'b1;
      if (w_start_run) begin
        r_pix  <= 32'd0;
        r_lane <= 2'd0;
        r_ovf  <= 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (w_clear) begin
          r_wp[i]  <= '0;
          r_rp[i]  <= '0;
          r_cnt[i] <= '0;
        end else begin
          if (w_push[i]) r_wp[i] <= r_wp[i] + AW'(1);
          if (w_pop[i])  r_rp[i] <= r_rp[i] + AW'(1);
          r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) r_mem[i][r_wp[i]] <= w_ldata[i];
    end
  end

  assign done        = (r_state == S_DONE);
  assign lane_full_0 = w_full[0];
  assign lane_full_1 = w_full[1];
  assign lane_full_2 = w_full[2];
  assign lane_full_3 = w_full[3];
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_en       = r_wr_en;
  assign mem_rw      = 1'b1;
  assign overflow    = r_ovf;
  assign pix_count   = r_pix;

endmodule
